// File: rtl/bist_pkg.sv
// Shared types and constants for the logic BIST controller: FSM states,
// MISR feedback polynomial and LFSR feedback taps.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } bist_state_e;

    localparam int          SIG_W      = 16;
    localparam logic [15:0] MISR_POLY  = 16'h1021;
    localparam int          LFSR_TAP_A = 6;
    localparam int          LFSR_TAP_B = 5;
    localparam int          CNT_W      = 7;

endpackage

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register: shift with CRC-style feedback,
// then XOR in the parallel response word.
module bist_misr
    import bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [SIG_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_next;

    always_comb begin
        sig_next = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0) ^ din;
    end

    // NOTE: non-blocking assignments for every register so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clear) begin
            sig <= '0;
        end else if (enable) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/bist_controller.sv
// Logic BIST controller: drives LFSR patterns into the CUT, compacts the
// responses in a MISR and compares the final signature against a golden value.
module bist_controller
    import bist_pkg::*;
#(
    parameter int               PI_W         = 7,
    parameter int               PO_W         = 4,
    parameter int               NUM_PATTERNS = 127,
    parameter logic [PI_W-1:0]  LFSR_SEED    = PI_W'(1),
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [PI_W-1:0]  cut_pi,
    input  logic [PO_W-1:0]  cut_po,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    generate
        if (NUM_PATTERNS < 1 || NUM_PATTERNS > 127) begin : g_bad_num_patterns
            $error("bist_controller: NUM_PATTERNS must be within 1..127");
        end
        if (LFSR_SEED == '0) begin : g_bad_seed
            $error("bist_controller: LFSR_SEED must be nonzero");
        end
        if (PI_W <= LFSR_TAP_A || PO_W > SIG_W) begin : g_bad_width
            $error("bist_controller: PI_W too narrow for LFSR taps or PO_W wider than MISR");
        end
    endgenerate

    bist_state_e      state_q, state_d;
    logic [PI_W-1:0]  lfsr;
    logic [CNT_W-1:0] cnt;
    logic             start_run;
    logic             misr_clear;
    logic             misr_en;
    logic             last_pattern;

    assign last_pattern = (cnt == CNT_W'(NUM_PATTERNS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort wins over everything, including a simultaneous start.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start) state_d = ST_RUN;
                ST_RUN:           if (last_pattern) state_d = ST_COMPARE;
                ST_COMPARE:       state_d = ST_DONE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        cut_pi     = '0;
        busy       = 1'b0;
        done       = 1'b0;
        start_run  = 1'b0;
        misr_en    = 1'b0;
        case (state_q)
            ST_IDLE:    start_run = start && !abort;
            ST_RUN: begin
                cut_pi  = lfsr;
                busy    = 1'b1;
                misr_en = !abort;
            end
            ST_COMPARE: busy = 1'b1;
            ST_DONE: begin
                done      = 1'b1;
                start_run = start && !abort;
            end
            default: ;
        endcase
        misr_clear = start_run;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
            cnt  <= '0;
            pass <= 1'b0;
        end else if (abort) begin
            pass <= 1'b0;
        end else if (start_run) begin
            lfsr <= LFSR_SEED;
            cnt  <= '0;
            pass <= 1'b0;
        end else if (state_q == ST_RUN) begin
            lfsr <= {lfsr[PI_W-2:0], lfsr[LFSR_TAP_A] ^ lfsr[LFSR_TAP_B]};
            cnt  <= cnt + CNT_W'(1);
        end else if (state_q == ST_COMPARE) begin
            pass <= (signature == GOLDEN_SIG);
        end
    end

    bist_misr u_misr (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (misr_clear),
        .enable (misr_en),
        .din    ({{(SIG_W - PO_W){1'b0}}, cut_po}),
        .sig    (signature)
    );

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller: pattern-order vector table plus
// hand-written full-run, abort, mid-run reset and short-run MISR sequences.
module tb_bist_controller;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, start2;
    logic        use_cut;
    logic [3:0]  po_const;
    logic [6:0]  cut_pi, cut_pi2a, cut_pi2b;
    logic [3:0]  cut_po;
    logic        busy, done, pass;
    logic        busy2a, done2a, pass2a, busy2b, done2b, pass2b;
    logic [15:0] signature, sig2a, sig2b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] cut_fn(input logic [6:0] pi);
        return pi[3:0] ^ {1'b0, pi[6:4]};
    endfunction

    assign cut_po = use_cut ? cut_fn(cut_pi) : po_const;

    bist_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cut_pi(cut_pi), .cut_po(cut_po), .busy(busy), .done(done),
        .pass(pass), .signature(signature)
    );

    bist_controller #(.NUM_PATTERNS(2), .GOLDEN_SIG(16'h0003)) dut2a (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
        .cut_pi(cut_pi2a), .cut_po(4'h1), .busy(busy2a), .done(done2a),
        .pass(pass2a), .signature(sig2a)
    );

    bist_controller #(.NUM_PATTERNS(2), .GOLDEN_SIG(16'h0004)) dut2b (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
        .cut_pi(cut_pi2b), .cut_po(4'h1), .busy(busy2b), .done(done2b),
        .pass(pass2b), .signature(sig2b)
    );

    // Reference model of the pattern generator and signature arithmetic.
    function automatic logic [6:0] model_lfsr_next(input logic [6:0] l);
        return {l[5:0], l[6] ^ l[5]};
    endfunction

    function automatic logic [15:0] model_misr_step(input logic [15:0] m, input logic [3:0] po);
        return ({m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000)) ^ {12'h000, po};
    endfunction

    function automatic logic [6:0] model_pattern(input int k);
        logic [6:0] l = 7'h01;
        for (int i = 1; i < k; i++) l = model_lfsr_next(l);
        return l;
    endfunction

    function automatic logic [15:0] model_sig(input int n);
        logic [6:0]  l = 7'h01;
        logic [15:0] m = 16'h0000;
        for (int i = 0; i < n; i++) begin
            m = model_misr_step(m, cut_fn(l));
            l = model_lfsr_next(l);
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until done rises; returns the number of edges taken.
    task automatic run_until_done(input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            step();
            cycles++;
        end
    endtask

    typedef struct {
        logic       start;
        logic       abort;
        logic [6:0] exp_pi;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int         cyc;
        logic [15:0] exp_sig;

        vecs[0]  = '{1'b1, 1'b0, 7'h01, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 7'h02, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 7'h04, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 7'h08, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 7'h10, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 7'h20, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 7'h41, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 7'h03, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 7'h06, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 7'h0C, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 7'h00, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 7'h01, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 7'h02, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 7'h00, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 7'h00, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 7'h00, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start2 = 1'b0;
        use_cut = 1'b0; po_const = 4'h0;
        step();
        step();
        check("reset cut_pi", 32'(cut_pi), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset pass", 32'(pass), 32'h0);
        check("reset signature", 32'(signature), 32'h0);
        rst_n = 1'b1;
        step();

        // Pattern order, start ignored in RUN, abort at RUN cycle 10, restart, abort priority.
        for (int i = 0; i < 16; i++) begin
            start = vecs[i].start;
            abort = vecs[i].abort;
            step();
            check($sformatf("vec%0d cut_pi", i), 32'(cut_pi), 32'(vecs[i].exp_pi));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].exp_done));
        end
        start = 1'b0; abort = 1'b0;

        // Zero response, full default run.
        start = 1'b1;
        step();
        start = 1'b0;
        run_until_done(400, cyc);
        check("zero latency", 32'(cyc + 1), 32'd129);
        check("zero signature", 32'(signature), 32'h0000);
        check("zero pass", 32'(pass), 32'h1);
        check("zero busy", 32'(busy), 32'h0);
        check("zero cut_pi", 32'(cut_pi), 32'h0);
        step(); step(); step();
        check("zero done held", 32'(done), 32'h1);
        check("zero pass held", 32'(pass), 32'h1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort from done", 32'(done), 32'h0);
        check("abort clears pass", 32'(pass), 32'h0);

        // Mid-run reset with a live CUT response, start pulse while busy.
        use_cut = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 2; c <= 50; c++) begin
            start = (c == 21);
            step();
        end
        start = 1'b0;
        check("run50 cut_pi", 32'(cut_pi), 32'(model_pattern(50)));
        check("run50 signature", 32'(signature), 32'(model_sig(49)));
        rst_n = 1'b0;
        step();
        check("midreset cut_pi", 32'(cut_pi), 32'h0);
        check("midreset busy", 32'(busy), 32'h0);
        check("midreset done", 32'(done), 32'h0);
        check("midreset pass", 32'(pass), 32'h0);
        check("midreset signature", 32'(signature), 32'h0);
        rst_n = 1'b1;
        step();

        exp_sig = model_sig(127);
        start = 1'b1;
        step();
        start = 1'b0;
        run_until_done(400, cyc);
        check("cut latency", 32'(cyc + 1), 32'd129);
        check("cut signature", 32'(signature), 32'(exp_sig));
        check("cut pass", 32'(pass), 32'(exp_sig == 16'h0000));

        start = 1'b1;
        step();
        start = 1'b0;
        check("restart busy", 32'(busy), 32'h1);
        check("restart done", 32'(done), 32'h0);
        check("restart pass", 32'(pass), 32'h0);
        check("restart cut_pi", 32'(cut_pi), 32'h01);
        run_until_done(400, cyc);
        check("restart latency", 32'(cyc + 1), 32'd129);
        check("restart signature", 32'(signature), 32'(exp_sig));
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort holds signature", 32'(signature), 32'(exp_sig));

        // Two-pattern run: signature 0003, pass only where golden matches.
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        step();
        step();
        check("n2 compare busy", 32'(busy2a), 32'h1);
        check("n2 compare done", 32'(done2a), 32'h0);
        check("n2 compare cut_pi", 32'(cut_pi2a), 32'h0);
        step();
        check("n2 done", 32'(done2a), 32'h1);
        check("n2 signature a", 32'(sig2a), 32'h0003);
        check("n2 signature b", 32'(sig2b), 32'h0003);
        check("n2 pass golden match", 32'(pass2a), 32'h1);
        check("n2 pass golden mismatch", 32'(pass2b), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bist_controller.md
BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 Parameter PI_W, 7, width of pattern driven to circuit-under-test (CUT) primary inputs.
REQ-002 Parameter PO_W, 4, width of CUT primary-output response.
REQ-003 Parameter NUM_PATTERNS, 127, patterns applied per run; legal range 1..127.
REQ-004 Parameter LFSR_SEED, 7'h01, initial pattern; nonzero.
REQ-005 Parameter GOLDEN_SIG, 16'h0000, expected 16-bit signature.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 start  input  1  one-cycle request to begin a run; sampled in IDLE or DONE only.
REQ-009 abort  input  1  terminate the run and return to IDLE.
REQ-010 cut_pi  output  PI_W  pattern to CUT inputs.
REQ-011 cut_po  input  PO_W  CUT response, combinational from cut_pi, same cycle.
REQ-012 busy  output  1  high in RUN and COMPARE.
REQ-013 done  output  1  high in DONE.
REQ-014 pass  output  1  signature match; valid while done.
REQ-015 signature  output  16  current MISR contents.

Function
REQ-016 States SHALL be IDLE, RUN, COMPARE, DONE.
REQ-017 IDLE/DONE with start=1 -> RUN; same edge: lfsr<=LFSR_SEED, misr<=0, cnt<=0, pass<=0.
REQ-018 In RUN, cut_pi SHALL equal lfsr; in all other states cut_pi SHALL be 0.
REQ-019 Each RUN edge: misr<=({misr[14:0],0} ^ (misr[15] ? 16'h1021 : 0)) ^ zero-extended cut_po; lfsr<={lfsr[5:0], lfsr[6]^lfsr[5]}; cnt<=cnt+1.
REQ-020 RUN edge with cnt==NUM_PATTERNS-1 SHALL absorb the final response and enter COMPARE; exactly NUM_PATTERNS responses absorbed.
REQ-021 COMPARE edge: pass<=(misr==GOLDEN_SIG), -> DONE; total latency start-to-done = NUM_PATTERNS+2 cycles.
REQ-022 DONE holds signature, pass, done until start (restart) or abort (-> IDLE).
REQ-023 start in RUN or COMPARE SHALL be ignored.
REQ-024 abort in any state SHALL -> IDLE next edge, pass<=0, misr and lfsr held; abort has priority over start.
REQ-025 NUM_PATTERNS=1: one RUN cycle, then COMPARE.
REQ-026 cnt width 7 bits; no wrap within a legal run.

Reset
REQ-027 rst_n=0 at an edge SHALL force state IDLE, lfsr=LFSR_SEED, misr=0, cnt=0, pass=0, regardless of state, including mid-RUN.
REQ-028 Reset outputs: cut_pi=0, busy=0, done=0, pass=0, signature=0.

Structure
REQ-029 Package bist_pkg SHALL hold the state enum, MISR polynomial 16'h1021, and LFSR tap positions.
REQ-030 The MISR SHALL be a sub-module bist_misr (clk, rst_n, clear, enable, din, sig).
REQ-031 Elaboration SHALL fail on LFSR_SEED==0 or NUM_PATTERNS outside 1..127.

Verification
REQ-032 Pattern order: defaults, start -> cut_pi over first 8 RUN cycles = 01,02,04,08,10,20,41,03.
REQ-033 Zero response: cut_po=0, defaults -> done after 129 cycles, signature=16'h0000, pass=1.
REQ-034 MISR math: NUM_PATTERNS=2, cut_po=4'h1 constant -> signature=16'h0003; GOLDEN_SIG=16'h0003 -> pass=1, else pass=0.
REQ-035 Abort: abort at RUN cycle 10 -> IDLE next edge, busy=0, done=0, cut_pi=0; a later start restarts from pattern 01.
REQ-036 Reset mid-run: rst_n=0 at RUN cycle 50 -> all REQ-028 values; start ignored while busy; restart from DONE gives an identical signature.
